keypad_hex_entry: RTL and testbench



---
 rtl/keypad_hex_entry_pkg.sv | 38 +++
 rtl/keypad_row_decode.sv | 27 ++
 rtl/keypad_hex_entry.sv | 159 +++++++++++++++
 tb/tb_keypad_hex_entry.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_hex_entry_pkg.sv
// Shared encodings and small helpers for the hex keypad entry block.
package keypad_hex_entry_pkg;

  // State encodings; the enum below is built on these values.
  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;

  typedef enum logic [1:0] {
    StScan    = SCAN,
    StPressDb = PRESS_DB,
    StHeld    = HELD
  } state_e;

  // First column driven after reset; rows read all-ones when nothing is pressed.
  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROW_IDLE  = 4'b1111;

  // Position of the single 0 in a one-cold column vector.
  function automatic logic [1:0] cold_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Advance the one-cold column drive: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] col_rotate(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/keypad_row_decode.sv
// Classifies the synchronised (active-low) row lines: a single low bit is a
// hit with its row index, all-ones is idle, anything else is a ghost.
module keypad_row_decode
  import keypad_hex_entry_pkg::*;
(
  input  logic [3:0] row_i,
  output logic       hit_o,
  output logic       ghost_o,
  output logic [1:0] row_idx_o
);

  // One-cold patterns are hits; every other non-idle pattern is a ghost.
  always_comb begin
    hit_o     = 1'b0;
    ghost_o   = 1'b0;
    row_idx_o = 2'd0;
    unique case (row_i)
      4'b1110: begin hit_o = 1'b1; row_idx_o = 2'd0; end
      4'b1101: begin hit_o = 1'b1; row_idx_o = 2'd1; end
      4'b1011: begin hit_o = 1'b1; row_idx_o = 2'd2; end
      4'b0111: begin hit_o = 1'b1; row_idx_o = 2'd3; end
      ROW_IDLE: ghost_o = 1'b0;
      default:  ghost_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// Scans a 4x4 hex keypad, debounces press and release, and shifts each
// accepted key code into a 16-bit value with the newest digit lowest.
module keypad_hex_entry
  import keypad_hex_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        IN_clk,
  input  logic        IN_rst,
  input  logic [3:0]  IN_row,
  input  logic        IN_clear,
  output logic [3:0]  OUT_col,
  output logic [15:0] OUT_value,
  output logic        OUT_key_valid,
  output logic [3:0]  OUT_key_code
);

  localparam logic [15:0] SlotLast = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DbLast   = 4'(DEBOUNCE - 1);

  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [3:0]  row_s;
  logic [15:0] slot_q;
  logic        tick;

  logic        hit;
  logic        ghost;
  logic        quiet;
  logic [1:0]  row_idx;
  logic [3:0]  key_code;
  logic        accept;

  state_e      state_q;
  logic [3:0]  col_q;
  logic [3:0]  ref_q;
  logic [3:0]  db_q;
  logic        valid_q;
  logic [3:0]  code_q;
  logic [15:0] value_q;

  // Two-flop synchroniser for the asynchronous row lines (idle = all ones).
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      sync1_q <= ROW_IDLE;
      sync2_q <= ROW_IDLE;
    end else begin
      sync1_q <= IN_row;
      sync2_q <= sync1_q;
    end
  end

  assign row_s = sync2_q;

  // Column slot counter; tick marks the last clock of each slot.
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      slot_q <= '0;
    end else if (tick) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + 16'd1;
    end
  end

  assign tick = (slot_q == SlotLast);

  keypad_row_decode u_row_decode (
    .row_i     (row_s),
    .hit_o     (hit),
    .ghost_o   (ghost),
    .row_idx_o (row_idx)
  );

  // Ghosts are indistinguishable from idle for scanning and release purposes.
  assign quiet    = ~hit | ghost;
  assign key_code = {row_idx, cold_index(col_q)};
  // The DEBOUNCE-th matching sample of the captured pattern accepts the key.
  assign accept   = tick && (state_q == StPressDb) && (row_s == ref_q) && (db_q == DbLast);

  // Scan / press-debounce / held FSM with registered column, pulse and code.
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      state_q <= StScan;
      col_q   <= COL_RESET;
      ref_q   <= ROW_IDLE;
      db_q    <= 4'd0;
      valid_q <= 1'b0;
      code_q  <= 4'd0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StScan: begin
            if (hit) begin
              state_q <= StPressDb;
              db_q    <= 4'd1;
              ref_q   <= row_s;
            end else begin
              col_q <= col_rotate(col_q);
            end
          end
          StPressDb: begin
            if (row_s == ref_q) begin
              if (accept) begin
                state_q <= StHeld;
                db_q    <= 4'd0;
                valid_q <= 1'b1;
                code_q  <= key_code;
              end else begin
                db_q <= db_q + 4'd1;
              end
            end else begin
              // Bounce: rescan from the same column on the next tick.
              state_q <= StScan;
              db_q    <= 4'd0;
            end
          end
          StHeld: begin
            // Any activity restarts the release count; no auto-repeat.
            if (quiet) begin
              if (db_q == DbLast) begin
                state_q <= StScan;
                db_q    <= 4'd0;
                col_q   <= col_rotate(col_q);
              end else begin
                db_q <= db_q + 4'd1;
              end
            end else begin
              db_q <= 4'd0;
            end
          end
          default: begin
            state_q <= StScan;
            db_q    <= 4'd0;
          end
        endcase
      end
    end
  end

  // Entered value shift register; a clear on the accept edge drops the key.
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      value_q <= 16'd0;
    end else if (IN_clear) begin
      value_q <= 16'd0;
    end else if (accept) begin
      value_q <= {value_q[11:0], key_code};
    end
  end

  assign OUT_col       = col_q;
  assign OUT_value     = value_q;
  assign OUT_key_valid = valid_q;
  assign OUT_key_code  = code_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry with SCAN_DIV=4, DEBOUNCE=3.
module tb_keypad_hex_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  code;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  logic        pressed = 1'b0;
  logic [3:0]  key = 4'h0;
  logic [3:0]  force_row = 4'hF;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always_comb begin
    row = force_row;
    if (pressed && (col[key[1:0]] == 1'b0)) row[key[3:2]] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  keypad_hex_entry #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .IN_clk        (clk),
    .IN_rst        (rst),
    .IN_row        (row),
    .IN_clear      (clear),
    .OUT_col       (col),
    .OUT_value     (value),
    .OUT_key_valid (valid),
    .OUT_key_code  (code)
  );

  function automatic logic [3:0] rot(input logic [3:0] c, input int n);
    logic [3:0] r;
    r = c;
    for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Tick edges are the edges where the cycle count since reset is a multiple of 4.
  task automatic next_tick();
    do clk1(); while ((cyc % 4) != 0);
  endtask

  task automatic align_col(input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      next_tick();
      if (col === target) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL align_col: OUT_col=%b never became required %b", col, target);
    end
  endtask

  task automatic press_key(input logic [3:0] k, input logic [15:0] exp_val);
    int p0;
    bit found;
    p0 = pulse_cnt;
    found = 1'b0;
    key = k;
    pressed = 1'b1;
    for (int i = 0; i < 80 && !found; i++) begin
      clk1();
      if (valid === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL key_%h_pulse: no pulse, required one", k); end
    vectors++;
    if (code !== k) begin miscompares++; $display("FAIL key_%h_code: got %h required %h", k, code, k); end
    vectors++;
    if (value !== exp_val) begin
      miscompares++; $display("FAIL key_%h_value: got %h required %h", k, value, exp_val);
    end
    repeat (20) clk1();
    pressed = 1'b0;
    repeat (30) clk1();
    vectors++;
    if (pulse_cnt - p0 != 1) begin
      miscompares++; $display("FAIL key_%h_pulses: got %0d required 1", k, pulse_cnt - p0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk1();
    vectors += 4;
    if (col !== 4'b1110) begin miscompares++; $display("FAIL reset_col: got %b required 1110", col); end
    if (value !== 16'h0) begin miscompares++; $display("FAIL reset_value: got %h required 0000", value); end
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", valid); end
    if (code !== 4'h0) begin miscompares++; $display("FAIL reset_code: got %h required 0", code); end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    int p0;
    logic [3:0] exp_col;
    p0 = pulse_cnt;
    for (int k = 1; k <= 200; k++) begin
      clk1();
      exp_col = rot(4'b1110, (k / 4) % 4);
      vectors++;
      if (col !== exp_col) begin
        miscompares++; $display("FAIL idle_col@%0d: got %b required %b", k, col, exp_col);
      end
    end
    vectors += 2;
    if (pulse_cnt != p0) begin miscompares++; $display("FAIL idle_pulses: got %0d required 0", pulse_cnt - p0); end
    if (value !== 16'h0) begin miscompares++; $display("FAIL idle_value: got %h required 0000", value); end
  endtask

  task automatic test_single_key();
    int p0;
    bit found;
    p0 = pulse_cnt;
    found = 1'b0;
    key = 4'h6;
    pressed = 1'b1;
    for (int i = 0; i < 80 && !found; i++) begin
      clk1();
      if (valid === 1'b1) found = 1'b1;
    end
    vectors += 4;
    if (!found) begin miscompares++; $display("FAIL single_pulse: no pulse, required one"); end
    if (code !== 4'h6) begin miscompares++; $display("FAIL single_code: got %h required 6", code); end
    if (value !== 16'h0006) begin miscompares++; $display("FAIL single_value: got %h required 0006", value); end
    if (col !== 4'b1011) begin miscompares++; $display("FAIL single_col: got %b required 1011", col); end
    repeat (30) clk1();
    vectors += 2;
    if (col !== 4'b1011) begin miscompares++; $display("FAIL held_col: got %b required 1011", col); end
    if (pulse_cnt - p0 != 1) begin
      miscompares++; $display("FAIL held_pulses: got %0d required 1", pulse_cnt - p0);
    end
    pressed = 1'b0;
    repeat (8) clk1();
    vectors++;
    if (col !== 4'b1011) begin miscompares++; $display("FAIL release_early: got %b required 1011", col); end
    found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      clk1();
      if (col === 4'b0111) found = 1'b1;
    end
    vectors += 2;
    if (!found) begin miscompares++; $display("FAIL release_resume: got %b required 0111", col); end
    if (pulse_cnt - p0 != 1) begin
      miscompares++; $display("FAIL release_pulses: got %0d required 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_sequence();
    clear = 1'b1;
    clk1();
    clear = 1'b0;
    vectors += 2;
    if (value !== 16'h0) begin miscompares++; $display("FAIL clear_value: got %h required 0000", value); end
    if (code !== 4'h6) begin miscompares++; $display("FAIL clear_code: got %h required 6", code); end
    press_key(4'h1, 16'h0001);
    press_key(4'h2, 16'h0012);
    press_key(4'h3, 16'h0123);
    press_key(4'h4, 16'h1234);
    press_key(4'h5, 16'h2345);
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    align_col(4'b1110);
    force_row = 4'b1110;
    next_tick();
    next_tick();
    force_row = 4'b1111;
    next_tick();
    vectors++;
    if (col !== 4'b1110) begin miscompares++; $display("FAIL bounce_col: got %b required 1110", col); end
    force_row = 4'b1110;
    next_tick();
    next_tick();
    vectors += 2;
    if (pulse_cnt != p0) begin miscompares++; $display("FAIL bounce_early: got %0d pulses required 0", pulse_cnt - p0); end
    if (valid !== 1'b0) begin miscompares++; $display("FAIL bounce_early_valid: got %b required 0", valid); end
    next_tick();
    vectors += 3;
    if (valid !== 1'b1) begin miscompares++; $display("FAIL bounce_valid: got %b required 1", valid); end
    if (code !== 4'h0) begin miscompares++; $display("FAIL bounce_code: got %h required 0", code); end
    if (value !== 16'h3450) begin miscompares++; $display("FAIL bounce_value: got %h required 3450", value); end
    force_row = 4'b1111;
    repeat (40) clk1();
    vectors++;
    if (pulse_cnt - p0 != 1) begin
      miscompares++; $display("FAIL bounce_pulses: got %0d required 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_ghost();
    int p0;
    p0 = pulse_cnt;
    force_row = 4'b1100;
    repeat (40) clk1();
    force_row = 4'b1111;
    repeat (10) clk1();
    vectors += 2;
    if (pulse_cnt != p0) begin miscompares++; $display("FAIL ghost_pulses: got %0d required 0", pulse_cnt - p0); end
    if (value !== 16'h3450) begin miscompares++; $display("FAIL ghost_value: got %h required 3450", value); end
  endtask

  task automatic test_clear_on_accept();
    clear = 1'b1;
    clk1();
    clear = 1'b0;
    press_key(4'h1, 16'h0001);
    press_key(4'h2, 16'h0012);
    press_key(4'h3, 16'h0123);
    align_col(4'b1101);
    force_row = 4'b1011;
    next_tick();
    next_tick();
    repeat (3) clk1();
    clear = 1'b1;
    clk1();
    clear = 1'b0;
    vectors += 3;
    if (valid !== 1'b1) begin miscompares++; $display("FAIL clracc_valid: got %b required 1", valid); end
    if (code !== 4'h9) begin miscompares++; $display("FAIL clracc_code: got %h required 9", code); end
    if (value !== 16'h0) begin miscompares++; $display("FAIL clracc_value: got %h required 0000", value); end
    force_row = 4'b1111;
    repeat (30) clk1();
  endtask

  task automatic test_reset_press_db();
    int p0;
    p0 = pulse_cnt;
    align_col(4'b1101);
    force_row = 4'b1110;
    next_tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors += 4;
    if (col !== 4'b1110) begin miscompares++; $display("FAIL rstdb_col: got %b required 1110", col); end
    if (code !== 4'h0) begin miscompares++; $display("FAIL rstdb_code: got %h required 0", code); end
    if (value !== 16'h0) begin miscompares++; $display("FAIL rstdb_value: got %h required 0000", value); end
    if (valid !== 1'b0) begin miscompares++; $display("FAIL rstdb_valid: got %b required 0", valid); end
    force_row = 4'b1111;
    repeat (3) clk1();
    rst = 1'b0;
    repeat (20) clk1();
    vectors++;
    if (pulse_cnt != p0) begin miscompares++; $display("FAIL rstdb_pulses: got %0d required 0", pulse_cnt - p0); end
  endtask

  task automatic test_reset_held();
    int p0;
    p0 = pulse_cnt;
    align_col(4'b1101);
    force_row = 4'b1101;
    next_tick();
    next_tick();
    next_tick();
    vectors += 2;
    if (valid !== 1'b1) begin miscompares++; $display("FAIL rsthld_accept: got %b required 1", valid); end
    if (code !== 4'h5) begin miscompares++; $display("FAIL rsthld_code5: got %h required 5", code); end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors += 4;
    if (col !== 4'b1110) begin miscompares++; $display("FAIL rsthld_col: got %b required 1110", col); end
    if (code !== 4'h0) begin miscompares++; $display("FAIL rsthld_code: got %h required 0", code); end
    if (value !== 16'h0) begin miscompares++; $display("FAIL rsthld_value: got %h required 0000", value); end
    if (valid !== 1'b0) begin miscompares++; $display("FAIL rsthld_valid: got %b required 0", valid); end
    force_row = 4'b1111;
    repeat (3) clk1();
    rst = 1'b0;
    repeat (20) clk1();
    vectors++;
    if (pulse_cnt - p0 != 1) begin
      miscompares++; $display("FAIL rsthld_pulses: got %0d required 1", pulse_cnt - p0);
    end
    press_key(4'h7, 16'h0007);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_sequence();
    test_bounce();
    test_ghost();
    test_clear_on_accept();
    test_reset_press_db();
    test_reset_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
